// File: rtl/router_reg_if.sv
// Bus between the router control FSM / source / FIFO side and the router_reg datapath stage.
// master = FSM/source/FIFO side (drives strobes and bytes), slave = router_reg.
interface router_reg_if #(
  parameter int DATA_WIDTH = 8
);
  // pkt_valid/data_in are consumed on any posedge where an FSM strobe selects them;
  // there is no ready: the FSM stalls the source itself while fifo_full is high.
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  ld_state;
  logic                  laf_state;
  logic                  lfd_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic                  parity_done;
  logic                  low_packet_valid;
  logic                  err;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           lfd_state, full_state, rst_int_reg,
    input  parity_done, low_packet_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           lfd_state, full_state, rst_int_reg,
    output parity_done, low_packet_valid, err, dout
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-stall hold byte, running parity and error flag.
// Optional saturating parity-error counter enabled by defining ROUTER_REG_ERR_CNT_EN.
module router_reg #(
  parameter int DATA_WIDTH = 8
`ifdef ROUTER_REG_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input  logic            clock,
  input  logic            resetn,
  router_reg_if.slave     bus
`ifdef ROUTER_REG_ERR_CNT_EN
  , output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic                  lpv_q, lpv_d;
  logic                  pd_q, pd_d;
  logic                  err_q, err_d;
  logic                  mismatch;

  assign mismatch = (int_par_q != pkt_par_q);

  always_comb begin
    hdr_d     = hdr_q;
    hold_d    = hold_q;
    dout_d    = dout_q;
    int_par_d = int_par_q;
    pkt_par_d = pkt_par_q;
    lpv_d     = lpv_q;
    pd_d      = pd_q;
    err_d     = err_q;

    // Address 2'b11 is not a valid destination, so such a header is never latched.
    if (bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11))
      hdr_d = bus.data_in;

    if (bus.lfd_state)
      dout_d = hdr_q;
    else if (bus.ld_state && !bus.fifo_full)
      dout_d = bus.data_in;
    else if (bus.ld_state)
      hold_d = bus.data_in;
    else if (bus.laf_state)
      dout_d = hold_q;
    else if (bus.full_state)
      dout_d = dout_q;

    // The parity byte itself (pkt_valid low) is stored, never folded into int_par.
    if (bus.detect_add)
      int_par_d = '0;
    else if (bus.lfd_state)
      int_par_d = int_par_q ^ hdr_q;
    else if (bus.ld_state && bus.pkt_valid)
      int_par_d = int_par_q ^ bus.data_in;

    if (bus.detect_add)
      pkt_par_d = '0;
    else if (bus.ld_state && !bus.pkt_valid)
      pkt_par_d = bus.data_in;

    if (bus.rst_int_reg)
      lpv_d = 1'b0;
    else if (bus.ld_state && !bus.pkt_valid)
      lpv_d = 1'b1;

    if (bus.detect_add)
      pd_d = 1'b0;
    else if (bus.ld_state && !bus.fifo_full && !bus.pkt_valid)
      pd_d = 1'b1;
    else if (bus.laf_state && lpv_q && !pd_q)
      pd_d = 1'b1;

    // err stays up until the next header so the FSM/host can observe it.
    if (bus.detect_add && bus.pkt_valid)
      err_d = 1'b0;
    else if (bus.rst_int_reg && !bus.detect_add)
      err_d = mismatch;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q     <= '0;
      hold_q    <= '0;
      dout_q    <= '0;
      int_par_q <= '0;
      pkt_par_q <= '0;
      lpv_q     <= 1'b0;
      pd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hdr_q     <= hdr_d;
      hold_q    <= hold_d;
      dout_q    <= dout_d;
      int_par_q <= int_par_d;
      pkt_par_q <= pkt_par_d;
      lpv_q     <= lpv_d;
      pd_q      <= pd_d;
      err_q     <= err_d;
    end
  end

  assign bus.dout             = dout_q;
  assign bus.parity_done      = pd_q;
  assign bus.low_packet_valid = lpv_q;
  assign bus.err              = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.rst_int_reg && !bus.detect_add && mismatch && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
